// File: rtl/rv32i_axi_master.sv
// rtl/rv32i_axi_master.sv - single-outstanding core memory port to AXI4-Lite master bridge
module rv32i_axi_master #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_instr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic              mem_valid,
  output logic [31:0]       mem_rdata,
  output logic              mem_error,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              instr_q;
  logic              aw_done;
  logic              w_done;

  logic aw_fire, w_fire, aw_ok, w_ok;
  assign aw_fire = m_axi_awvalid & m_axi_awready;
  assign w_fire  = m_axi_wvalid & m_axi_wready;
  assign aw_ok   = aw_done | aw_fire;
  assign w_ok    = w_done | w_fire;

  // Payloads come straight from the captured request, so they hold until handshake.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_awprot = {instr_q, 2'b00};
  assign m_axi_arprot = {instr_q, 2'b00};
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      instr_q       <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      mem_ready     <= 1'b0;
      mem_valid     <= 1'b0;
      mem_rdata     <= '0;
      mem_error     <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      mem_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_req) begin
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            wstrb_q   <= mem_wstrb;
            instr_q   <= mem_instr;
            mem_ready <= 1'b0;
            if (mem_we) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= S_AW_W;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= S_AR;
            end
          end else begin
            mem_ready <= 1'b1;
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            mem_rdata    <= (m_axi_rresp == 2'b00) ? m_axi_rdata : ERR_RDATA;
            mem_error    <= (m_axi_rresp != 2'b00);
            mem_valid    <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_AW_W: begin
          // AW and W retire independently; B waits until both have handshaken.
          if (aw_fire) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_fire) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            m_axi_bready <= 1'b1;
            state        <= S_B;
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            mem_error    <= (m_axi_bresp != 2'b00);
            mem_valid    <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          // Never accept here: the core may still be holding mem_req this cycle.
          mem_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_axi_master.sv
// tb/tb_rv32i_axi_master.sv - directed self-checking bench for rv32i_axi_master
module tb_rv32i_axi_master;
  logic        clk, rst;
  logic        mem_req, mem_we, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_valid, mem_error;
  logic [31:0] mem_rdata;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int compared = 0;
  int mismatched = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, mv_cnt = 0;

  rv32i_axi_master #(.ADDR_W(32), .ERR_RDATA(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (arvalid && arready) ar_hs++;
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready) w_hs++;
      if (bvalid && bready) b_hs++;
      if (mem_valid) mv_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (mem_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic req(input logic we, input logic instr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    mem_req = 1'b1; mem_we = we; mem_instr = instr;
    mem_addr = a; mem_wdata = d; mem_wstrb = s;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    rst = 1'b1;
    step(); step();
    outs = {mem_ready, mem_valid, mem_error, awvalid, wvalid, bready, arvalid, rready};
    compared++;
    if (outs !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want 00000000", outs);
    end
    compared++;
    if (mem_rdata !== 32'h0 || araddr !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_regs: rdata=%h araddr=%h want 0", mem_rdata, araddr);
    end
    rst = 1'b0;
    step();
    compared++;
    if (mem_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got %b want 1", mem_ready);
    end
  endtask

  task automatic test_read();
    int n, ar0;
    ar0 = ar_hs;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
    req(1'b0, 1'b1, 32'h0000_2004, 32'h0, 4'h0);
    step();
    compared++;
    if (arvalid !== 1'b1 || arprot !== 3'b100 || araddr !== 32'h0000_2004) begin
      mismatched++;
      $display("FAIL read_ar: arvalid=%b arprot=%b araddr=%h want 1 100 00002004", arvalid, arprot, araddr);
    end
    wait_valid(n);
    n = n + 1;
    compared++;
    if (n !== 3) begin
      mismatched++;
      $display("FAIL read_latency: got %0d cycles want 3", n);
    end
    compared++;
    if (mem_rdata !== 32'h1234_5678 || mem_error !== 1'b0) begin
      mismatched++;
      $display("FAIL read_data: rdata=%h err=%b want 12345678 0", mem_rdata, mem_error);
    end
    // mem_req still held across the DONE edge, then dropped
    step();
    compared++;
    if (mem_valid !== 1'b0 || arvalid !== 1'b0) begin
      mismatched++;
      $display("FAIL read_pulse: mem_valid=%b arvalid=%b want 0 0", mem_valid, arvalid);
    end
    mem_req = 1'b0;
    step(); step(); step();
    compared++;
    if (ar_hs - ar0 !== 1) begin
      mismatched++;
      $display("FAIL read_no_reissue: ar handshakes=%0d want 1", ar_hs - ar0);
    end
  endtask

  task automatic test_write_aw_late();
    int n, aw0, w0, b0, mv0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; mv0 = mv_cnt;
    awready = 1'b0; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    req(1'b1, 1'b0, 32'h0000_0100, 32'hCAFE_F00D, 4'b0011);
    step();
    compared++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h100 || wdata !== 32'hCAFE_F00D
        || wstrb !== 4'b0011 || awprot !== 3'b000) begin
      mismatched++;
      $display("FAIL write_issue: awv=%b wv=%b awaddr=%h wdata=%h wstrb=%b awprot=%b", awvalid, wvalid, awaddr, wdata, wstrb, awprot);
    end
    mem_req = 1'b0;
    step(); step(); step();
    compared++;
    if (wvalid !== 1'b0 || awvalid !== 1'b1) begin
      mismatched++;
      $display("FAIL write_hold: wvalid=%b awvalid=%b want 0 1", wvalid, awvalid);
    end
    awready = 1'b1;
    wait_valid(n);
    compared++;
    if (n !== 2) begin
      mismatched++;
      $display("FAIL write_late_done: mem_valid after %0d cycles want 2", n);
    end
    step(); step();
    compared++;
    if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1 || b_hs - b0 !== 1 || mv_cnt - mv0 !== 1) begin
      mismatched++;
      $display("FAIL write_counts: aw=%0d w=%0d b=%0d mv=%0d want 1 1 1 1", aw_hs - aw0, w_hs - w0, b_hs - b0, mv_cnt - mv0);
    end
  endtask

  task automatic test_write_order();
    int n, aw0, w0, b0, mv0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; mv0 = mv_cnt;
    awready = 1'b0; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    req(1'b1, 1'b0, 32'h0000_0200, 32'h1111_2222, 4'hF);
    step();
    mem_req = 1'b0;
    step();
    awready = 1'b1;
    wait_valid(n);
    compared++;
    if (n !== 2) begin
      mismatched++;
      $display("FAIL write_w_first: mem_valid after %0d cycles want 2", n);
    end
    step();
    awready = 1'b1; wready = 1'b1;
    req(1'b1, 1'b0, 32'h0000_0204, 32'h3333_4444, 4'hF);
    wait_valid(n);
    mem_req = 1'b0;
    compared++;
    if (n !== 3) begin
      mismatched++;
      $display("FAIL write_same_cycle: latency %0d want 3", n);
    end
    step(); step();
    compared++;
    if (aw_hs - aw0 !== 2 || w_hs - w0 !== 2 || b_hs - b0 !== 2 || mv_cnt - mv0 !== 2) begin
      mismatched++;
      $display("FAIL write_order_counts: aw=%0d w=%0d b=%0d mv=%0d want 2 2 2 2", aw_hs - aw0, w_hs - w0, b_hs - b0, mv_cnt - mv0);
    end
  endtask

  task automatic test_errors();
    int n;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    req(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    wait_valid(n);
    mem_req = 1'b0;
    compared++;
    if (n !== 3 || mem_error !== 1'b1 || mem_rdata !== 32'h0000_0000) begin
      mismatched++;
      $display("FAIL read_slverr: n=%0d err=%b rdata=%h want 3 1 00000000", n, mem_error, mem_rdata);
    end
    step();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b11;
    req(1'b1, 1'b0, 32'h0000_0304, 32'h5, 4'h1);
    wait_valid(n);
    mem_req = 1'b0;
    compared++;
    if (n !== 3 || mem_error !== 1'b1) begin
      mismatched++;
      $display("FAIL write_decerr: n=%0d err=%b want 3 1", n, mem_error);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n, ar0;
    ar0 = ar_hs;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hA5A5_0001; rresp = 2'b00;
    req(1'b0, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
    wait_valid(n);
    // keep mem_req high with a new address: must only be taken once back in IDLE
    mem_addr = 32'h0000_0404;
    rdata = 32'hA5A5_0002;
    step();
    compared++;
    if (arvalid !== 1'b0 || mem_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_done_ignore: arvalid=%b mem_valid=%b want 0 0", arvalid, mem_valid);
    end
    step();
    compared++;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_0404) begin
      mismatched++;
      $display("FAIL b2b_second_ar: arvalid=%b araddr=%h want 1 00000404", arvalid, araddr);
    end
    mem_req = 1'b0;
    wait_valid(n);
    compared++;
    if (mem_rdata !== 32'hA5A5_0002 || ar_hs - ar0 !== 2) begin
      mismatched++;
      $display("FAIL b2b_second_read: rdata=%h ar=%0d want a5a50002 2", mem_rdata, ar_hs - ar0);
    end
    step();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    req(1'b1, 1'b0, 32'h0000_0408, 32'hFFFF_FFFF, 4'hF);
    wait_valid(n);
    mem_req = 1'b0;
    compared++;
    if (mem_rdata !== 32'hA5A5_0002 || mem_error !== 1'b0) begin
      mismatched++;
      $display("FAIL write_keeps_rdata: rdata=%h err=%b want a5a50002 0", mem_rdata, mem_error);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int mv0;
    logic [5:0] outs;
    arready = 1'b1; rvalid = 1'b0; rresp = 2'b00;
    req(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    step(); step();
    mem_req = 1'b0;
    compared++;
    if (rready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_inR: rready=%b want 1", rready);
    end
    rst = 1'b1;
    step();
    outs = {awvalid, wvalid, bready, arvalid, rready, mem_ready};
    compared++;
    if (outs !== 6'b000000) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: got %b want 000000", outs);
    end
    rst = 1'b0;
    rvalid = 1'b1;
    mv0 = mv_cnt;
    step();
    compared++;
    if (mem_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_ready: got %b want 1", mem_ready);
    end
    step(); step(); step();
    compared++;
    if (mv_cnt - mv0 !== 0 || rready !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_no_valid: pulses=%0d rready=%b want 0 0", mv_cnt - mv0, rready);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_req = 1'b0; mem_we = 1'b0; mem_instr = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    test_reset();
    test_read();
    test_write_aw_late();
    test_write_order();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
